// File: rtl/fifo_pkt_reader.sv
// Length-prefixed packet reader: pops a header word L from a show-ahead FIFO, then forwards
// L payload words with sop/eop framing. Define FIFO_PKT_READER_PKT_CNT_EN for the packet counter.
module fifo_pkt_reader #(
   parameter int unsigned data_width = 8,
   parameter int unsigned cnt_width  = 16
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic [data_width-1:0] rd_data,
   input  logic                  empty_flag,
   output logic                  rd_en,
   output logic [data_width-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_sop,
   output logic                  out_eop,
   output logic                  busy,
   output logic [cnt_width-1:0]  pkt_count
);

   typedef enum logic {S_HDR, S_PAYLOAD} state_t;

   state_t                state_q, state_d;
   logic [data_width-1:0] rem_q, rem_d;
   logic                  first_q, first_d;
   logic [data_width-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  sop_q, sop_d;
   logic                  eop_q, eop_d;

   logic last_word;
   assign last_word = (rem_q == data_width'(1));

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      first_d = first_q;
      data_d  = data_q;
      // Output register drains on handshake in both states unless reloaded below.
      valid_d = valid_q && !out_ready;
      sop_d   = sop_q;
      eop_d   = eop_q;
      rd_en   = 1'b0;
      unique case (state_q)
         S_HDR: begin
            rd_en = !empty_flag && !rd_rst;
            if (rd_en && (rd_data != '0)) begin
               rem_d   = rd_data;
               first_d = 1'b1;
               state_d = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            rd_en = !empty_flag && (!valid_q || out_ready) && !rd_rst;
            if (rd_en) begin
               data_d  = rd_data;
               valid_d = 1'b1;
               sop_d   = first_q;
               eop_d   = last_word;
               first_d = 1'b0;
               rem_d   = rem_q - data_width'(1);
               if (last_word) begin
                  state_d = S_HDR;
               end
            end
         end
         default: state_d = S_HDR;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q <= S_HDR;
         rem_q   <= '0;
         first_q <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         first_q <= first_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_sop   = sop_q;
   assign out_eop   = eop_q;
   assign busy      = (state_q == S_PAYLOAD);

`ifdef FIFO_PKT_READER_PKT_CNT_EN
   logic [cnt_width-1:0] cnt_q;

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         cnt_q <= '0;
      end else if (valid_q && out_ready && eop_q) begin
         cnt_q <= cnt_q + cnt_width'(1);
      end
   end

   assign pkt_count = cnt_q;
`else
   assign pkt_count = '0;
`endif

endmodule

// File: doc/fifo_pkt_reader.md
FIFO_PKT_READER -- requirements
Module: fifo_pkt_reader

Interface
REQ-001 SHALL have parameter data_width, default 8, giving the FIFO word width and the output data width.
REQ-002 SHALL have parameter cnt_width, default 16, giving the pkt_count width.
REQ-003 SHALL have port rd_clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rd_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rd_data  input  data_width  FIFO read-side data, valid whenever empty_flag=0.
REQ-006 SHALL have port empty_flag  input  1  FIFO empty indication.
REQ-007 SHALL have port rd_en  output  1  FIFO pop strobe.
REQ-008 SHALL have port out_data  output  data_width  payload word.
REQ-009 SHALL have port out_valid  output  1  out_data, out_sop and out_eop are valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-011 SHALL have port out_sop  output  1  first payload word of a packet.
REQ-012 SHALL have port out_eop  output  1  last payload word of a packet.
REQ-013 SHALL have port busy  output  1  asserted while in S_PAYLOAD.
REQ-014 SHALL have port pkt_count  output  cnt_width  completed-packet counter (see Configuration).

Function
REQ-015 SHALL frame the FIFO stream as packets: one header word whose unsigned value L is the payload length, followed by L payload words.
REQ-016 SHALL implement states S_HDR (await header) and S_PAYLOAD (forward payload), with a down-counter rem of data_width bits.
REQ-017 SHALL drive rd_en combinationally: in S_HDR, rd_en = !empty_flag; in S_PAYLOAD, rd_en = !empty_flag && (!out_valid || out_ready).
REQ-018 SHALL never assert rd_en while empty_flag=1.
REQ-019 SHALL sample rd_data in the same cycle rd_en is high; the FIFO output is combinational from the current read address.
REQ-020 On a header pop with L=0, SHALL remain in S_HDR, produce no output and leave pkt_count unchanged.
REQ-021 On a header pop with L>0, SHALL load rem=L, set an internal first flag and move to S_PAYLOAD on the next edge.
REQ-022 On a payload pop, SHALL load the output register on the next edge: out_data=rd_data, out_valid=1, out_sop=first, out_eop=(rem==1); it SHALL then clear first and decrement rem.
REQ-023 When popping the last word (rem==1), SHALL return to S_HDR on the same edge, so a following header may be popped in the next cycle.
REQ-024 SHALL have latency of exactly one cycle from payload pop to out_valid, with sustained throughput of 1 word/cycle while the FIFO is non-empty and out_ready=1.
REQ-025 SHALL hold out_valid, out_data, out_sop and out_eop stable while out_valid=1 and out_ready=0.
REQ-026 SHALL clear out_valid after a handshake (out_valid && out_ready) unless a new word is loaded on the same edge.
REQ-027 While in S_HDR, SHALL keep the output register draining, so a pending eop word may be accepted while the next header is popped.
REQ-028 SHALL wait in S_PAYLOAD, with no timeout, when the FIFO goes empty mid-packet.
REQ-029 SHALL treat rem as unsigned; L = 2^data_width-1 is a legal maximum and SHALL NOT wrap.

Reset
REQ-030 SHALL, while rd_rst=1 at a rising edge, set state=S_HDR, rem=0, first=0, out_valid=0, out_sop=0, out_eop=0, out_data=0 and pkt_count=0.
REQ-031 SHALL hold rd_en=0 while rd_rst=1.
REQ-032 SHALL, on reset mid-packet, discard the partial packet and resume in S_HDR, treating the next FIFO word as a header.

Configuration
REQ-033 With macro FIFO_PKT_READER_PKT_CNT_EN defined, SHALL increment pkt_count by 1 on each handshake with out_eop=1, wrapping modulo 2^cnt_width.
REQ-034 Without FIFO_PKT_READER_PKT_CNT_EN, SHALL keep the pkt_count port and tie it to constant 0 with no counter logic.

Verification
REQ-035 SHALL cover: FIFO holds 3,A,B,C with out_ready=1 -> rd_en high 4 consecutive cycles; out_data A,B,C on consecutive cycles; sop on A, eop on C.
REQ-036 SHALL cover: FIFO holds 0,1,D -> header 0 consumed silently; single-word packet D output with out_sop=1 and out_eop=1.
REQ-037 SHALL cover: packet 2,E,F with out_ready=0 for 5 cycles after E appears -> E held stable, rd_en=0 during stall, F follows 1 cycle after ready rises.
REQ-038 SHALL cover: packet 4,G,H then empty 10 cycles, then I,J -> busy=1 throughout, no rd_en while empty, eop on J.
REQ-039 SHALL cover: rd_rst pulse after 2 words of a 5-word packet, then 1,K -> all outputs 0 after reset; K output with sop=1 and eop=1.
REQ-040 SHALL cover: with FIFO_PKT_READER_PKT_CNT_EN and cnt_width=2, 5 packets sent -> pkt_count sequence 1,2,3,0,1; without the macro, pkt_count=0.
